seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for the 8-digit common-anode 7-segment display on the Nexys A7.

---
 rtl/seg7_scan_driver_if.sv | 21 ++
 rtl/seg7_scan_driver.sv | 163 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display value/control in, anode/cathode drive out.
// master = value producer (CPU side), slave = scan driver.
interface seg7_scan_driver_if;
  logic [31:0] DISREG;
  logic [7:0]  DP;
  logic        EN;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DPN;
  logic        FRAME;

  modport master (
    output DISREG, DP, EN,
    input  AN, SEG, DPN, FRAME
  );

  modport slave (
    input  DISREG, DP, EN,
    output AN, SEG, DPN, FRAME
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit multiplexed hex display driver (Nexys A7).
// Optional LEADING_ZERO_BLANK_EN: leading-zero blanking per 16-bit half.
module seg7_scan_driver #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 2000
) (
  input logic               CLK,
  input logic               RSTN,
  seg7_scan_driver_if.slave disp
);
  localparam int PW =
    (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIGIT_CYCLES - 1);
  localparam logic [PW-1:0] GEND = PW'(GUARD_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_e;

  state_e      state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] snap_q, snap_d;
  logic [7:0]  sdp_q, sdp_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dpn_q, dpn_d;
  logic        frame_q, frame_d;
  logic        take;
  logic        wrap;
  logic        hide;
  logic [3:0]  nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    unique case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] blank_q, blank_d;

  // Lowest digit of each half is never blanked.
  function automatic logic [3:0] lz(input logic [15:0] h);
    logic [3:0] b;
    b[3] = (h[15:12] == 4'h0);
    b[2] = b[3] && (h[11:8] == 4'h0);
    b[1] = b[2] && (h[7:4] == 4'h0);
    b[0] = 1'b0;
    return b;
  endfunction

  assign hide = blank_q[idx_q];
`else
  assign hide = 1'b0;
`endif

  assign wrap = (pre_q == PMAX);
  assign nib  = 4'(snap_q >> {idx_q, 2'b00});

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    sdp_d   = sdp_q;
    an_d    = 8'hFF;
    seg_d   = 7'h7F;
    dpn_d   = 1'b1;
    take    = 1'b0;
    if (!disp.EN) begin
      state_d = S_IDLE;
      pre_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          take    = 1'b1;
          state_d = S_SCAN;
          pre_d   = '0;
          idx_d   = '0;
        end
        S_SCAN: begin
          pre_d = wrap ? '0 : pre_q + 1'b1;
          if (wrap)
            idx_d = idx_q + 3'd1;
          take = wrap && (idx_q == 3'd7);
          if (pre_q >= GEND) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = hide ? 7'h7F : hex7(nib);
            dpn_d = ~sdp_q[idx_q];
          end
        end
      endcase
    end
    frame_d = take;
    if (take) begin
      snap_d = disp.DISREG;
      sdp_d  = disp.DP;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank_d = blank_q;
    if (take)
      blank_d = {lz(disp.DISREG[31:16]),
                 lz(disp.DISREG[15:0])};
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      blank_q <= '0;
    else
      blank_q <= blank_d;
  end
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      sdp_q   <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dpn_q   <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      sdp_q   <= sdp_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpn_q   <= dpn_d;
      frame_q <= frame_d;
    end
  end

  assign disp.AN    = an_q;
  assign disp.SEG   = seg_q;
  assign disp.DPN   = dpn_q;
  assign disp.FRAME = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: random DISREG/DP/EN traffic vs. a time-based
// reference model of the scanned display (DIGIT_CYCLES=8, GUARD_CYCLES=2).
module tb_seg7_scan_driver;
  localparam int DC = 8;
  localparam int GC = 2;
  localparam int FL = DC * 8;

  logic CLK = 1'b0;
  logic RSTN;
  int   n_vec = 0;
  int   n_err = 0;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .DIGIT_CYCLES(DC),
    .GUARD_CYCLES(GC)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .disp(bus.slave)
  );

  always #5 CLK = ~CLK;

  logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  bit          m_run;
  int          m_t;
  logic [31:0] m_snap;
  logic [7:0]  m_dp;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dpn;
  logic        e_frame;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "_AN"},    32'(bus.AN),    32'(e_an));
    chk({pfx, "_SEG"},   32'(bus.SEG),   32'(e_seg));
    chk({pfx, "_DPN"},   32'(bus.DPN),   32'(e_dpn));
    chk({pfx, "_FRAME"}, 32'(bus.FRAME), 32'(e_frame));
  endtask

  task automatic model_reset();
    m_run   = 0;
    m_t     = 0;
    m_snap  = '0;
    m_dp    = '0;
    e_an    = 8'hFF;
    e_seg   = 7'h7F;
    e_dpn   = 1'b1;
    e_frame = 1'b0;
  endtask

  function automatic bit shown(input int s, input logic [31:0] v);
`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0] half;
    int          pos;
    half = (s >= 4) ? v[31:16] : v[15:0];
    pos  = s % 4;
    return (pos == 0) || ((half >> (4 * pos)) != 0);
`else
    return (s >= 0) && (v === v);
`endif
  endfunction

  // Outputs after an edge depend on the time within the run before it.
  task automatic model_step();
    int s;
    int w;
    e_an  = 8'hFF;
    e_seg = 7'h7F;
    e_dpn = 1'b1;
    if (bus.EN && m_run) begin
      s = (m_t / DC) % 8;
      w = m_t % DC;
      if (w >= GC) begin
        e_an  = ~(8'd1 << s);
        e_seg = shown(s, m_snap) ? HEX[(m_snap >> (4 * s)) & 32'hF]
                                 : 7'h7F;
        e_dpn = ~m_dp[s];
      end
    end
    e_frame = bus.EN && (!m_run || (m_t % FL) == FL - 1);
    if (!bus.EN) begin
      m_run = 0;
    end else if (e_frame) begin
      m_snap = bus.DISREG;
      m_dp   = bus.DP;
      m_t    = m_run ? m_t + 1 : 0;
      m_run  = 1;
    end else begin
      m_t = m_t + 1;
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] v;
    for (int i = 0; i < 8; i++)
      v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0
                                                 : 4'($urandom);
    return v;
  endfunction

  initial begin
    RSTN       = 1'b0;
    bus.EN     = 1'b1;
    bus.DISREG = 32'h1234ABCD;
    bus.DP     = 8'h00;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_all("rst");
    @(negedge CLK);
    RSTN = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge CLK);
      model_step();
      #1;
      check_all("run");
      if (c == 2500) begin
        #2;
        RSTN = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge CLK);
        RSTN = 1'b1;
      end
      if (c < 200) begin
        bus.EN = 1'b1;
        if (c == 20) bus.DISREG = 32'h000F0020;
        if (c == 90) bus.DP = 8'h01;
      end else begin
        bus.EN = ($urandom_range(0, 249) != 0);
        if ($urandom_range(0, 3) == 0) bus.DISREG = rand_word();
        if ($urandom_range(0, 15) == 0) bus.DP = 8'($urandom);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
